// File: rtl/riscv_bus_pkg.sv
// Shared types and constants for the core-to-memory bus.
package riscv_bus_pkg;

    localparam int MEM_AW_DEFAULT = 10;

    typedef enum logic {
        MST_IF = 1'b0,
        MST_LS = 1'b1
    } mst_e;

    localparam logic [3:0]  BE_WORD  = 4'hF;
    localparam logic [3:0]  BE_NONE  = 4'h0;
    localparam logic [15:0] PERF_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the master that was not granted last wins a tie.
module rr_arb2
    import riscv_bus_pkg::*;
(
    input  logic       clock,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    mst_e last_q, last_d;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (!rst) begin
            if (req_i[MST_IF] && (!req_i[MST_LS] || last_q == MST_LS)) begin
                gnt_o[MST_IF] = 1'b1;
            end else if (req_i[MST_LS]) begin
                gnt_o[MST_LS] = 1'b1;
            end
        end
        if (gnt_o[MST_IF]) begin
            last_d = MST_IF;
        end else if (gnt_o[MST_LS]) begin
            last_d = MST_LS;
        end
    end

    // Starting from LS lets instruction fetch win the very first conflict.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            last_q <= MST_LS;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port synchronous memory between the IF and LS ports of the core,
// routing the one-cycle-late read data back to whichever master owned the access.
module riscv_mem_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = MEM_AW_DEFAULT
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       perf_conflicts
);

    logic [1:0]        req, gnt;
    logic              ls_sel, any_gnt, is_write, out_of_range;
    logic [ADDR_W-1:0] addr;
    logic              unused_addr_lsb;

    mst_e              resp_owner_q, resp_owner_d;
    logic              resp_v_q, resp_v_d;
    logic              resp_rd_q, resp_rd_d;
    logic              resp_err_q, resp_err_d;
    logic [15:0]       perf_q, perf_d;
    logic [DATA_W-1:0] resp_data;

    assign req = {ls_req, if_req};

    rr_arb2 u_arb (
        .clock (clock),
        .rst   (rst),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign if_gnt   = gnt[MST_IF];
    assign ls_gnt   = gnt[MST_LS];
    assign ls_sel   = gnt[MST_LS];
    assign any_gnt  = |gnt;
    assign is_write = ls_sel && ls_we;

    assign addr            = ls_sel ? ls_addr : if_addr;
    assign out_of_range    = |addr[ADDR_W-1:MEM_AW+2];
    assign unused_addr_lsb = ^addr[1:0];

    // Out-of-range accesses are still granted, but never reach the macro.
    assign mem_en    = any_gnt && !out_of_range;
    assign mem_we    = (is_write && !out_of_range) ? ls_be : BE_NONE;
    assign mem_addr  = addr[MEM_AW+1:2];
    assign mem_wdata = ls_wdata;

    always_comb begin
        resp_v_d     = any_gnt;
        resp_owner_d = resp_owner_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        if (any_gnt) begin
            resp_owner_d = ls_sel ? MST_LS : MST_IF;
            resp_rd_d    = !is_write;
            resp_err_d   = out_of_range;
        end
    end

    assign perf_d = (if_req && ls_req && perf_q != PERF_MAX) ? perf_q + 16'd1 : perf_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            resp_v_q     <= 1'b0;
            resp_owner_q <= MST_IF;
            resp_rd_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            perf_q       <= '0;
        end else begin
            resp_v_q     <= resp_v_d;
            resp_owner_q <= resp_owner_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
            perf_q       <= perf_d;
        end
    end

    // Write acknowledges and errored reads return zero rather than stale macro output.
    assign resp_data = (resp_v_q && resp_rd_q && !resp_err_q) ? mem_rdata : '0;

    assign if_rvalid = resp_v_q && (resp_owner_q == MST_IF);
    assign ls_rvalid = resp_v_q && (resp_owner_q == MST_LS);
    assign if_rdata  = (resp_owner_q == MST_IF) ? resp_data : '0;
    assign ls_rdata  = (resp_owner_q == MST_LS) ? resp_data : '0;
    assign if_err    = if_rvalid && resp_err_q;
    assign ls_err    = ls_rvalid && resp_err_q;

    assign perf_conflicts = perf_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench: vector table for grants/strobes, scoreboard queue for responses.
module tb_riscv_mem_arbiter;
    import riscv_bus_pkg::*;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [3:0]  ls_be;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic        exp_if_gnt;
        logic        exp_ls_gnt;
        logic        exp_mem_en;
        logic [3:0]  exp_mem_we;
    } vec_t;

    typedef struct {
        logic        v;
        logic        owner_ls;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clock = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] perf_conflicts;

    logic [31:0] env_mem [1024];
    logic [31:0] ref_mem [1024];
    resp_t       sb_q [$];
    vec_t        vecs [15];
    logic [15:0] model_conf;
    int          n_checks = 0;
    int          n_fail   = 0;

    riscv_mem_arbiter dut (
        .clock          (clock),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_rvalid      (if_rvalid),
        .if_rdata       (if_rdata),
        .if_err         (if_err),
        .ls_req         (ls_req),
        .ls_we          (ls_we),
        .ls_be          (ls_be),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_gnt         (ls_gnt),
        .ls_rvalid      (ls_rvalid),
        .ls_rdata       (ls_rdata),
        .ls_err         (ls_err),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .perf_conflicts (perf_conflicts)
    );

    always #5 clock = ~clock;

    // Behavioural single-port memory macro with one-cycle read latency.
    always @(posedge clock) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= env_mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic [31:0] ia,
                                input logic lr, input logic lw, input logic [3:0] lb,
                                input logic [31:0] la, input logic [31:0] lwd,
                                input logic eif, input logic els, input logic een,
                                input logic [3:0] ewe);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;
        v.ls_req = lr;  v.ls_we = lw;  v.ls_be = lb;  v.ls_addr = la;  v.ls_wdata = lwd;
        v.exp_if_gnt = eif;  v.exp_ls_gnt = els;  v.exp_mem_en = een;  v.exp_mem_we = ewe;
        return v;
    endfunction

    function automatic resp_t no_resp();
        resp_t r;
        r.v = 1'b0;  r.owner_ls = 1'b0;  r.rdata = '0;  r.err = 1'b0;
        return r;
    endfunction

    task automatic check_resp(input int idx);
        resp_t e;
        if (sb_q.size() == 0) begin
            check($sformatf("v%0d scoreboard_empty", idx), 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check($sformatf("v%0d if_rvalid", idx), if_rvalid, e.v && !e.owner_ls);
        check($sformatf("v%0d ls_rvalid", idx), ls_rvalid, e.v && e.owner_ls);
        check($sformatf("v%0d if_rdata", idx), if_rdata, (e.v && !e.owner_ls) ? e.rdata : 32'd0);
        check($sformatf("v%0d ls_rdata", idx), ls_rdata, (e.v && e.owner_ls) ? e.rdata : 32'd0);
        if (e.v && e.owner_ls)  check($sformatf("v%0d ls_err", idx), ls_err, e.err);
        if (e.v && !e.owner_ls) check($sformatf("v%0d if_err", idx), if_err, e.err);
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic apply_vec(input vec_t v, input int idx);
        resp_t       e;
        logic [31:0] ga;
        logic        oor, wr;
        if_req = v.if_req;  if_addr = v.if_addr;
        ls_req = v.ls_req;  ls_we = v.ls_we;  ls_be = v.ls_be;
        ls_addr = v.ls_addr;  ls_wdata = v.ls_wdata;
        @(negedge clock);
        check($sformatf("v%0d if_gnt", idx), if_gnt, v.exp_if_gnt);
        check($sformatf("v%0d ls_gnt", idx), ls_gnt, v.exp_ls_gnt);
        check($sformatf("v%0d mem_en", idx), mem_en, v.exp_mem_en);
        check($sformatf("v%0d mem_we", idx), mem_we, v.exp_mem_we);
        ga = v.exp_ls_gnt ? v.ls_addr : v.if_addr;
        if (v.exp_mem_en) check($sformatf("v%0d mem_addr", idx), mem_addr, ga[11:2]);
        if (v.exp_mem_we != BE_NONE) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.ls_wdata);
        check_resp(idx);
        check($sformatf("v%0d perf_conflicts", idx), perf_conflicts, model_conf);

        oor = |ga[31:12];
        wr  = v.exp_ls_gnt && v.ls_we;
        e.v        = v.exp_if_gnt || v.exp_ls_gnt;
        e.owner_ls = v.exp_ls_gnt;
        e.err      = oor;
        e.rdata    = (e.v && !wr && !oor) ? ref_mem[ga[11:2]] : 32'd0;
        if (wr && !oor) begin
            for (int b = 0; b < 4; b++) begin
                if (v.ls_be[b]) ref_mem[ga[11:2]][8*b +: 8] = v.ls_wdata[8*b +: 8];
            end
        end
        sb_q.push_back(e);
        if (v.if_req && v.ls_req && model_conf != 16'hFFFF) model_conf++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        env_mem[0] = 32'h0000_0013;  ref_mem[0] = 32'h0000_0013;
        env_mem[1] = 32'h1111_1111;  ref_mem[1] = 32'h1111_1111;
        env_mem[2] = 32'h2222_2222;  ref_mem[2] = 32'h2222_2222;
        mem_rdata  = '0;
        model_conf = '0;

        //             if_req if_addr       ls_req we be       ls_addr       ls_wdata      gIF gLS en we
        vecs[0]  = mk(1, 32'h0000_0000, 0, 0, BE_NONE, 32'h0,        32'h0,        1, 0, 1, BE_NONE);
        vecs[1]  = mk(0, 32'h0,        1, 1, 4'b0001, 32'h0000_0100, 32'h5555_55AA, 0, 1, 1, 4'b0001);
        vecs[2]  = mk(1, 32'h0000_0100, 0, 0, BE_NONE, 32'h0,        32'h0,        1, 0, 1, BE_NONE);
        vecs[3]  = mk(0, 32'h0,        1, 0, BE_WORD, 32'h0000_1000, 32'h0,        0, 1, 0, BE_NONE);
        vecs[4]  = mk(1, 32'h0000_0004, 1, 0, BE_WORD, 32'h0000_0008, 32'h0,        1, 0, 1, BE_NONE);
        vecs[5]  = mk(1, 32'h0000_0004, 1, 0, BE_WORD, 32'h0000_0008, 32'h0,        0, 1, 1, BE_NONE);
        vecs[6]  = mk(1, 32'h0000_0004, 1, 0, BE_WORD, 32'h0000_0008, 32'h0,        1, 0, 1, BE_NONE);
        vecs[7]  = mk(1, 32'h0000_0004, 1, 0, BE_WORD, 32'h0000_0008, 32'h0,        0, 1, 1, BE_NONE);
        vecs[8]  = mk(0, 32'h0,        0, 0, BE_NONE, 32'h0,        32'h0,        0, 0, 0, BE_NONE);
        vecs[9]  = mk(0, 32'h0,        1, 1, BE_WORD, 32'h0000_1100, 32'hDEAD_BEEF, 0, 1, 0, BE_NONE);
        vecs[10] = mk(1, 32'h0000_0100, 0, 0, BE_NONE, 32'h0,        32'h0,        1, 0, 1, BE_NONE);
        vecs[11] = mk(0, 32'h0,        1, 1, BE_WORD, 32'h0000_0104, 32'hCAFE_F00D, 0, 1, 1, BE_WORD);
        vecs[12] = mk(1, 32'h8000_0000, 1, 0, BE_WORD, 32'h0000_0104, 32'h0,        1, 0, 0, BE_NONE);
        vecs[13] = mk(1, 32'h8000_0000, 1, 0, BE_WORD, 32'h0000_0104, 32'h0,        0, 1, 1, BE_NONE);
        vecs[14] = mk(0, 32'h0,        0, 0, BE_NONE, 32'h0,        32'h0,        0, 0, 0, BE_NONE);

        // Reset with both masters requesting: nothing may be granted or strobed.
        rst = 1'b1;
        if_req = 1'b1;  if_addr = '0;
        ls_req = 1'b1;  ls_we = 1'b1;  ls_be = BE_WORD;  ls_addr = 32'h4;  ls_wdata = 32'h1234_5678;
        repeat (2) @(negedge clock);
        check("rst if_gnt", if_gnt, 32'd0);
        check("rst ls_gnt", ls_gnt, 32'd0);
        check("rst mem_en", mem_en, 32'd0);
        check("rst mem_we", mem_we, 32'd0);
        check("rst if_rvalid", if_rvalid, 32'd0);
        check("rst ls_rvalid", ls_rvalid, 32'd0);
        check("rst if_rdata", if_rdata, 32'd0);
        check("rst ls_rdata", ls_rdata, 32'd0);
        check("rst perf_conflicts", perf_conflicts, 32'd0);
        rst = 1'b0;  if_req = 1'b0;  ls_req = 1'b0;  ls_we = 1'b0;
        sb_q.push_back(no_resp());
        @(posedge clock);
        #1;

        for (int i = 0; i < 15; i++) apply_vec(vecs[i], i);
        check_resp(15);
        check("perf after table", perf_conflicts, 32'd6);

        // Reset in the cycle after an IF grant: its response must be discarded.
        sb_q.push_back(no_resp());
        apply_vec(mk(1, 32'h4, 0, 0, BE_NONE, 32'h0, 32'h0, 1, 0, 1, BE_NONE), 100);
        rst = 1'b1;
        if_req = 1'b1;  if_addr = 32'h4;  ls_req = 1'b1;  ls_addr = 32'h8;  ls_we = 1'b0;
        @(negedge clock);
        check("midrst if_rvalid", if_rvalid, 32'd0);
        check("midrst if_rdata", if_rdata, 32'd0);
        check("midrst if_gnt", if_gnt, 32'd0);
        check("midrst ls_gnt", ls_gnt, 32'd0);
        check("midrst perf_conflicts", perf_conflicts, 32'd0);
        sb_q.delete();
        model_conf = '0;
        rst = 1'b0;  if_req = 1'b0;  ls_req = 1'b0;
        sb_q.push_back(no_resp());
        @(posedge clock);
        #1;
        apply_vec(vecs[14], 101);
        apply_vec(mk(1, 32'h4, 1, 0, BE_WORD, 32'h8, 32'h0, 1, 0, 1, BE_NONE), 102);
        apply_vec(vecs[14], 103);

        // Saturation of the conflict counter.
        rst = 1'b1;  if_req = 1'b0;  ls_req = 1'b0;
        @(negedge clock);
        rst = 1'b0;
        if_req = 1'b1;  if_addr = 32'h0;  ls_req = 1'b1;  ls_we = 1'b0;  ls_addr = 32'h4;
        repeat (65534) @(posedge clock);
        @(negedge clock);
        check("sat perf 0xFFFE", perf_conflicts, 32'h0000_FFFE);
        @(posedge clock);
        @(negedge clock);
        check("sat perf 0xFFFF", perf_conflicts, 32'h0000_FFFF);
        repeat (4500) @(posedge clock);
        @(negedge clock);
        check("sat perf held", perf_conflicts, 32'h0000_FFFF);
        check("sat one grant", {31'd0, if_gnt ^ ls_gnt}, 32'd1);
        if_req = 1'b0;  ls_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
